// File: rtl/fft_uart_pkg.sv
// fft_uart_pkg: shared byte width, serializer state enum and bytes-per-word helper
package fft_uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int bytes_of(input int len);
    return 2 * len / BYTE_W;
  endfunction
endpackage

// File: rtl/fft_tx_serializer_if.sv
// fft_tx_serializer_if: word in (fft_data/tx_valid/tx_ready), byte out (byte/byte_valid/byte_ready), stop, frame_done, busy
interface fft_tx_serializer_if #(parameter int length = 32);
  logic [2*length-1:0] i_fft_data;
  logic                i_tx_valid;
  logic                o_tx_ready;
  logic                i_stop;
  logic [7:0]          o_byte;
  logic                o_byte_valid;
  logic                i_byte_ready;
  logic                o_frame_done;
  logic                o_busy;
  modport master (
    output i_fft_data, i_tx_valid, i_stop, i_byte_ready,
    input  o_tx_ready, o_byte, o_byte_valid, o_frame_done, o_busy
  );
  modport slave (
    input  i_fft_data, i_tx_valid, i_stop, i_byte_ready,
    output o_tx_ready, o_byte, o_byte_valid, o_frame_done, o_busy
  );
endinterface

// File: rtl/fft_tx_serializer_frame_counter.sv
// frame_counter: counts words modulo DATA_LENGTH (clk, rst, clr, inc in; wrap out on the final increment)
module frame_counter #(
  parameter int DATA_LENGTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic wrap
);
  localparam int CW = $clog2(DATA_LENGTH + 1);
  logic [CW-1:0] cnt;
  assign wrap = inc && cnt == CW'(DATA_LENGTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fft_tx_serializer.sv
// fft_tx_serializer: splits 2*length-bit words MSB-first into bytes (i_clk, i_rst async, bus: word in, byte out, stop, frame_done, busy)
module fft_tx_serializer
  import fft_uart_pkg::*;
#(
  parameter int length      = 32,
  parameter int DATA_LENGTH = 256
) (
  input logic               i_clk,
  input logic               i_rst,
  fft_tx_serializer_if.slave bus
);
  localparam int W     = 2 * length;
  localparam int BYTES = bytes_of(length);
  localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
  state_t        state;
  logic [W-1:0]  shreg;
  logic [IW-1:0] idx;
  logic          tx_ready, byte_valid, frame_done, xfer, last, wrap;
  assign xfer = byte_valid & bus.i_byte_ready;
  assign last = idx == IW'(BYTES - 1);
  frame_counter #(.DATA_LENGTH(DATA_LENGTH)) u_frame_counter (
    .clk (i_clk),
    .rst (i_rst),
    .clr (bus.i_stop),
    .inc (xfer & last & ~bus.i_stop),
    .wrap(wrap)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      tx_ready   <= 1'b1;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (bus.i_stop) begin
      state      <= IDLE;
      idx        <= '0;
      tx_ready   <= 1'b1;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (state == IDLE) begin
        if (bus.i_tx_valid) begin
          shreg      <= bus.i_fft_data;
          idx        <= '0;
          state      <= SEND;
          tx_ready   <= 1'b0;
          byte_valid <= 1'b1;
        end
      end else if (xfer) begin
        shreg <= shreg << BYTE_W;
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          state      <= IDLE;
          tx_ready   <= 1'b1;
          byte_valid <= 1'b0;
        end
      end
    end
  assign bus.o_tx_ready   = tx_ready;
  assign bus.o_byte_valid = byte_valid;
  assign bus.o_byte       = shreg[W-1 -: BYTE_W];
  assign bus.o_frame_done = frame_done;
  assign bus.o_busy       = state == SEND;
endmodule

// File: tb/tb_fft_tx_serializer.sv
// tb_fft_tx_serializer: directed table-driven bench with DATA_LENGTH=4 and hand sequences for abort, collision, throughput and reset
module tb_fft_tx_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  fft_tx_serializer_if #(.length(32)) bus ();
  fft_tx_serializer #(.length(32), .DATA_LENGTH(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );
  typedef struct {
    logic [63:0] data;
    logic [15:0] pat;
    logic [63:0] exp;
    logic        done;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_word(input logic [63:0] d, input logic [15:0] pat, input logic [63:0] exp, input logic done);
    int k = 0;
    int c = 0;
    @(negedge clk);
    chk("idle_ready", bus.o_tx_ready, 1);
    chk("idle_done_low", bus.o_frame_done, 0);
    bus.i_fft_data = d;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    while (k < 8 && c < 40) begin
      bus.i_byte_ready = pat[c % 16];
      chk("send_valid", bus.o_byte_valid, 1);
      chk("send_ready_low", bus.o_tx_ready, 0);
      chk("send_busy", bus.o_busy, 1);
      chk("send_done_low", bus.o_frame_done, 0);
      chk("send_byte", bus.o_byte, exp[63-8*k -: 8]);
      @(negedge clk);
      if (bus.i_byte_ready) k++;
      c++;
    end
    bus.i_byte_ready = 1'b0;
    chk("word_bytes", k, 8);
    chk("end_valid", bus.o_byte_valid, 0);
    chk("end_ready", bus.o_tx_ready, 1);
    chk("end_frame_done", bus.o_frame_done, done);
  endtask
  initial begin
    int lows;
    int k;
    bus.i_fft_data   = '0;
    bus.i_tx_valid   = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_byte_ready = 1'b0;
    tbl[0] = '{64'h0123456789ABCDEF, 16'hFFFF, 64'h0123456789ABCDEF, 1'b0};
    tbl[1] = '{64'h0123456789ABCDEF, 16'h9999, 64'h0123456789ABCDEF, 1'b0};
    tbl[2] = '{64'hFEDCBA9876543210, 16'hFFFF, 64'hFEDCBA9876543210, 1'b0};
    tbl[3] = '{64'h00FF00FFA5A55A5A, 16'hAAAA, 64'h00FF00FFA5A55A5A, 1'b1};
    tbl[4] = '{64'h8000000000000001, 16'hFFFF, 64'h8000000000000001, 1'b0};
    tbl[5] = '{64'hDEADBEEFCAFEF00D, 16'h9999, 64'hDEADBEEFCAFEF00D, 1'b0};
    tbl[6] = '{64'h0000000000000000, 16'hFFFF, 64'h0000000000000000, 1'b0};
    tbl[7] = '{64'hFFFFFFFFFFFFFFFF, 16'hAAAA, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    #23 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", bus.o_tx_ready, 1);
    chk("rst_byte_valid", bus.o_byte_valid, 0);
    chk("rst_byte", bus.o_byte, 8'h00);
    chk("rst_frame_done", bus.o_frame_done, 0);
    chk("rst_busy", bus.o_busy, 0);
    for (int i = 0; i < 8; i++) run_word(tbl[i].data, tbl[i].pat, tbl[i].exp, tbl[i].done);
    run_word(64'h1111111111111111, 16'hFFFF, 64'h1111111111111111, 1'b0);
    @(negedge clk);
    bus.i_fft_data = 64'h0123456789ABCDEF;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid   = 1'b0;
    bus.i_byte_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("stop_pre_byte", bus.o_byte, 8'h67);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    chk("stop_valid", bus.o_byte_valid, 0);
    chk("stop_ready", bus.o_tx_ready, 1);
    chk("stop_busy", bus.o_busy, 0);
    @(negedge clk);
    chk("stop_no_more", bus.o_byte_valid, 0);
    bus.i_byte_ready = 1'b0;
    run_word(64'h0102030405060708, 16'hFFFF, 64'h0102030405060708, 1'b0);
    run_word(64'h1020304050607080, 16'hFFFF, 64'h1020304050607080, 1'b0);
    run_word(64'hA0B0C0D0E0F00011, 16'h9999, 64'hA0B0C0D0E0F00011, 1'b0);
    run_word(64'h5555AAAA5555AAAA, 16'hFFFF, 64'h5555AAAA5555AAAA, 1'b1);
    @(negedge clk);
    bus.i_fft_data = 64'hCCCCCCCCCCCCCCCC;
    bus.i_tx_valid = 1'b1;
    bus.i_stop     = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    bus.i_stop     = 1'b0;
    chk("collide_valid", bus.o_byte_valid, 0);
    chk("collide_ready", bus.o_tx_ready, 1);
    chk("collide_busy", bus.o_busy, 0);
    bus.i_fft_data   = 64'h1122334455667788;
    bus.i_tx_valid   = 1'b1;
    bus.i_byte_ready = 1'b1;
    lows = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (!bus.o_tx_ready) lows++;
      if (c < 8) chk("b2b_byte", bus.o_byte, 8'h11 * (c + 1));
      else chk("b2b_gap_valid", bus.o_byte_valid, 0);
    end
    chk("b2b_ready_lows", lows, 8);
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    chk("b2b_second_valid", bus.o_byte_valid, 1);
    chk("b2b_second_byte", bus.o_byte, 8'h11);
    k = 0;
    while (bus.o_byte_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_second_len", k, 8);
    bus.i_byte_ready = 1'b0;
    bus.i_fft_data   = 64'h0123456789ABCDEF;
    bus.i_tx_valid   = 1'b1;
    @(negedge clk);
    bus.i_tx_valid   = 1'b0;
    bus.i_byte_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.i_byte_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_ready", bus.o_tx_ready, 1);
    chk("arst_byte_valid", bus.o_byte_valid, 0);
    chk("arst_byte", bus.o_byte, 8'h00);
    chk("arst_frame_done", bus.o_frame_done, 0);
    chk("arst_busy", bus.o_busy, 0);
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("arst_hold_idle", bus.o_byte_valid, 0);
    run_word(64'hFEDCBA9876543210, 16'hFFFF, 64'hFEDCBA9876543210, 1'b0);
    run_word(64'h0123456789ABCDEF, 16'hFFFF, 64'h0123456789ABCDEF, 1'b0);
    run_word(64'h0123456789ABCDEF, 16'h9999, 64'h0123456789ABCDEF, 1'b0);
    run_word(64'h0123456789ABCDEF, 16'hFFFF, 64'h0123456789ABCDEF, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_tx_serializer.md
# fft_tx_serializer

Downstream stage of the FFT controller. Accepts one complex FFT result word per valid/ready transfer, splits it into bytes MSB-first, and presents them one at a time to the UART transmitter over a byte valid/ready handshake. It also counts result words per frame and pulses `o_frame_done` after the last byte of the last word has been handed off.

## Interface
- `length`, default 32: bit width of each real/imag part; the word is `2*length` bits. `2*length` must be a multiple of 8.
- `DATA_LENGTH`, default 256: result words per frame; must be ≥1.
- `i_clk` input 1: system clock.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_fft_data` input `2*length`: result word, real part in the upper half.
- `i_tx_valid` input 1: `i_fft_data` is valid.
- `o_tx_ready` output 1: serializer can accept a word.
- `i_stop` input 1: synchronous abort, clears the frame and drops any word in flight.
- `o_byte` output 8: byte to the UART transmitter.
- `o_byte_valid` output 1: `o_byte` is valid.
- `i_byte_ready` input 1: UART transmitter accepts `o_byte` this cycle.
- `o_frame_done` output 1: one-cycle pulse at end of frame.
- `o_busy` output 1: a word is being serialized.

## Operation
- Constants:
  - `BYTES = 2*length/8` (8 at default).
  - Byte index counter is `$clog2(BYTES)` bits.
  - Word counter is `$clog2(DATA_LENGTH+1)` bits.
- State machine has two states, IDLE and SEND.
- **IDLE**
  - `o_tx_ready=1`, `o_byte_valid=0`.
  - When `i_tx_valid & o_tx_ready`: load `i_fft_data` into the shift register, clear the byte index, go to SEND.
- **SEND**
  - `o_tx_ready=0`, `o_byte_valid=1`.
  - `o_byte` = shift register bits `[2*length-1 -: 8]`.
  - When `i_byte_valid & i_byte_ready` (a transfer):
    - Shift left by 8 and increment the byte index.
    - If the index was `BYTES-1`:
      - Increment the word counter.
      - Go to IDLE.
      - If the word counter was `DATA_LENGTH-1`: set the counter to 0 and pulse `o_frame_done` next cycle.
- While `o_byte_valid` is high, `o_byte` must stay stable until it is transferred.
- `o_busy` is high in SEND.
- **`i_stop`** has priority over every other event in any state.
  - Next cycle: state IDLE, byte index 0, word counter 0, `o_frame_done` 0.
  - A word offered in the same cycle as `i_stop` is not accepted, even if `o_tx_ready=1`.
  - The transmitter may already have accepted a byte in that same cycle; no bytes follow it.
- Arithmetic: all counters are unsigned and wrap by explicit compare, never by overflow.

## Timing
- Reset values:
  - `o_tx_ready=1`, `o_byte_valid=0`, `o_byte=8'h00`, `o_frame_done=0`, `o_busy=0`.
  - Internally: state IDLE, counters 0, shift register 0.
- Latency:
  - Word accepted at edge t gives the first byte valid from t+1.
  - With `i_byte_ready` held high, the word takes `BYTES` cycles in SEND, then 1 cycle in IDLE.
  - Throughput is therefore one word per `BYTES+1` cycles.
- `o_tx_ready` is a registered level; it is not combinationally dependent on `i_byte_ready`.
- `o_frame_done` is registered: high exactly one cycle, on the cycle after the final byte transfer. That cycle is the same cycle IDLE is re-entered.
- Backpressure: `i_byte_ready` low in SEND holds state, `o_byte` and the byte index indefinitely.
- Asynchronous reset mid-word discards all state; no partial bytes are emitted afterward.

## Structure
- Shared package `fft_uart_pkg`:
  - `BYTES` derivation function.
  - State enum: IDLE, SEND.
  - Byte-width constant `8`.
- A single module is sufficient. The optional frame counter may be a sub-module `frame_counter` (`DATA_LENGTH` modulus, increment and clear inputs, wrap pulse output); it is not required.

## Test plan
- Basic word: `i_fft_data=64'h0123456789ABCDEF`, `i_byte_ready=1` → bytes `01 23 45 67 89 AB CD EF` on consecutive cycles t+1..t+8. `o_tx_ready` is low for exactly 8 cycles.
- Backpressure: same word, `i_byte_ready` toggling 1,0,0,1,… → `o_byte` holds during each low period, the 8 bytes keep their order, nothing is dropped or duplicated.
- Frame end: `DATA_LENGTH=4`, four back-to-back words with `i_tx_valid` held high → 32 bytes. `o_frame_done` pulses once, the cycle after the 32nd transfer. A fifth word restarts the count, with no pulse until the 8th word.
- Abort: `i_stop` asserted after the 3rd byte of a word → next cycle `o_byte_valid=0`, `o_tx_ready=1`. The next frame then needs a full `DATA_LENGTH` words before `o_frame_done`.
- Reset mid-word: assert `i_rst` asynchronously (between clock edges) during SEND → outputs take reset values immediately. After release, a new word serializes from its first byte.
- Stop/valid collision: `i_stop` and `i_tx_valid` high together in IDLE → word not accepted, state stays IDLE.
